// File: rtl/clk_div_bank_if.sv
// Control and observation bundle for clk_div_bank: enables, config/mask writes,
// and the divided outputs. The master drives control; the divider bank is the slave.
interface clk_div_bank_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8
);
   localparam int unsigned CH_W = 3;

   logic              ena;
   logic              sync;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_mode;
   logic              mask_we;
   logic [NUM_CH-1:0] mask_in;
   logic [NUM_CH-1:0] div_out;
   logic [NUM_CH-1:0] tick;
   logic              y;

   modport master (
      output ena, sync, cfg_we, cfg_ch, cfg_div, cfg_mode, mask_we, mask_in,
      input  div_out, tick, y
   );

   modport slave (
      input  ena, sync, cfg_we, cfg_ch, cfg_div, cfg_mode, mask_we, mask_in,
      output div_out, tick, y
   );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable down-counter dividers producing clock-enable-style
// divided waveforms and terminal-count ticks on clk, plus a masked AND of the outputs.
module clk_div_bank #(
   parameter int unsigned       NUM_CH   = 4,
   parameter int unsigned       CNT_W    = 8,
   parameter logic [NUM_CH-1:0] MASK_RST = NUM_CH'(4'b0101)
) (
   input logic            clk,
   input logic            rst_n,
   clk_div_bank_if.slave  bus
);
   localparam int unsigned CH_W = 3;

   logic [CNT_W-1:0]  r_div [NUM_CH];
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_mode;
   logic [NUM_CH-1:0] r_div_out;
   logic [NUM_CH-1:0] r_tick;
   logic [NUM_CH-1:0] r_mask;

   logic [NUM_CH-1:0] w_wr;
   logic [CNT_W-1:0]  w_ld [NUM_CH];
   logic              w_y;

   // Reset divide value 2^ch - 1 gives divide-by-2/4/8/16... in toggle mode.
   function automatic logic [CNT_W-1:0] rst_div(input int unsigned ch);
      return CNT_W'((32'd1 << ch) - 32'd1);
   endfunction

   // A same-edge config write overrides the reload value of its channel.
   always_comb begin
      w_wr = '0;
      w_ld = '{default: '0};
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         w_wr[ch] = bus.cfg_we && (bus.cfg_ch == CH_W'(ch));
         w_ld[ch] = w_wr[ch] ? bus.cfg_div : r_div[ch];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            r_div[ch] <= rst_div(ch);
            r_cnt[ch] <= rst_div(ch);
         end
         r_mode    <= '0;
         r_div_out <= '0;
         r_tick    <= '0;
         r_mask    <= MASK_RST;
      end else begin
         if (bus.mask_we) r_mask <= bus.mask_in;
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (w_wr[ch]) begin
               r_div[ch]  <= bus.cfg_div;
               r_mode[ch] <= bus.cfg_mode;
            end
            if (bus.sync) begin
               r_cnt[ch]     <= w_ld[ch];
               r_div_out[ch] <= 1'b0;
               r_tick[ch]    <= 1'b0;
            end else if (bus.ena) begin
               if (r_cnt[ch] == '0) begin
                  r_tick[ch]    <= 1'b1;
                  r_cnt[ch]     <= w_ld[ch];
                  r_div_out[ch] <= r_mode[ch] ? 1'b1 : ~r_div_out[ch];
               end else begin
                  r_tick[ch] <= 1'b0;
                  r_cnt[ch]  <= r_cnt[ch] - CNT_W'(1);
                  if (r_mode[ch]) r_div_out[ch] <= 1'b0;
               end
            end else begin
               // Frozen: count and toggle output hold, pulse output drops.
               r_tick[ch] <= 1'b0;
               if (r_mode[ch]) r_div_out[ch] <= 1'b0;
            end
         end
      end
   end

   // An empty mask would otherwise reduce to 1; force y low instead.
   assign w_y = (r_mask != '0) && (&(r_div_out | ~r_mask));

   assign bus.div_out = r_div_out;
   assign bus.tick    = r_tick;
   assign bus.y       = w_y;
endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized + directed bench for clk_div_bank: an event-time reference model
// pushes expected outputs into a queue; a monitor pops and compares each cycle.
module tb_clk_div_bank;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [NUM_CH-1:0] d;
      logic [NUM_CH-1:0] t;
      logic              y;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_n    = 0;
   bit   done     = 0;

   // Reference model: each channel tracks how many enabled edges have elapsed
   // since its last restart and the absolute edge number of its next tick.
   int                m_d    [NUM_CH];
   bit                m_mode [NUM_CH];
   int                m_en   [NUM_CH];
   int                m_next [NUM_CH];
   logic [NUM_CH-1:0] m_out, m_tick, m_mask;

   task automatic model_step();
      exp_t x;
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_d[c]    = (1 << c) - 1;
            m_mode[c] = 0;
            m_en[c]   = 0;
            m_next[c] = m_d[c] + 1;
         end
         m_out  = '0;
         m_tick = '0;
         m_mask = 4'b0101;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            bit wr;
            int new_d;
            wr    = bus.cfg_we && (int'(bus.cfg_ch) == c);
            new_d = wr ? int'(bus.cfg_div) : m_d[c];
            if (bus.sync) begin
               m_out[c]  = 1'b0;
               m_tick[c] = 1'b0;
               m_en[c]   = 0;
               m_next[c] = new_d + 1;
            end else if (bus.ena) begin
               m_en[c] = m_en[c] + 1;
               if (m_en[c] == m_next[c]) begin
                  m_tick[c] = 1'b1;
                  m_next[c] = m_en[c] + new_d + 1;
                  m_out[c]  = m_mode[c] ? 1'b1 : ~m_out[c];
               end else begin
                  m_tick[c] = 1'b0;
                  if (m_mode[c]) m_out[c] = 1'b0;
               end
            end else begin
               m_tick[c] = 1'b0;
               if (m_mode[c]) m_out[c] = 1'b0;
            end
            if (wr) begin
               m_d[c]    = int'(bus.cfg_div);
               m_mode[c] = bus.cfg_mode;
            end
         end
         if (bus.mask_we) m_mask = bus.mask_in;
      end
      x.d = m_out;
      x.t = m_tick;
      x.y = (m_mask != '0) && ((m_out | ~m_mask) == '1);
      q.push_back(x);
   endtask

   task automatic cyc(input logic r, input logic e, input logic s, input logic cw,
                      input logic [2:0] cc, input logic [7:0] cd, input logic cm,
                      input logic mw, input logic [3:0] mi);
      @(negedge clk);
      rst_n        = r;
      bus.ena      = e;
      bus.sync     = s;
      bus.cfg_we   = cw;
      bus.cfg_ch   = cc;
      bus.cfg_div  = cd;
      bus.cfg_mode = cm;
      bus.mask_we  = mw;
      bus.mask_in  = mi;
      model_step();
   endtask

   task automatic run(input int n, input logic e);
      for (int i = 0; i < n; i++) cyc(1'b1, e, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic rst(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 4'd0);
   endtask

   // Monitor: outputs are presented every cycle; sample 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      cyc_n++;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (bus.div_out !== e.d) begin
            failures++;
            $display("FAIL div_out cyc=%0d got=%b exp=%b", cyc_n, bus.div_out, e.d);
         end
         checks++;
         if (bus.tick !== e.t) begin
            failures++;
            $display("FAIL tick cyc=%0d got=%b exp=%b", cyc_n, bus.tick, e.t);
         end
         checks++;
         if (bus.y !== e.y) begin
            failures++;
            $display("FAIL y cyc=%0d got=%b exp=%b", cyc_n, bus.y, e.y);
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      bus.ena      = 1'b0;
      bus.sync     = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_div  = '0;
      bus.cfg_mode = 1'b0;
      bus.mask_we  = 1'b0;
      bus.mask_in  = '0;

      // Defaults: divide-by-2/4/8/16.
      rst(2);
      run(40, 1'b1);

      // ch1 D=4 mid-count, then an out-of-range channel write.
      run(1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'd4, 1'b0, 1'b0, 4'd0);
      run(20, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 1'b1, 1'b0, 4'd0);
      run(12, 1'b1);

      // ch0 pulse mode D=2, then a 3-cycle freeze.
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'd2, 1'b1, 1'b0, 4'd0);
      run(10, 1'b1);
      run(3, 1'b0);
      run(12, 1'b1);

      // sync at arbitrary phase, then sync with ch2 D=9.
      run(7, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 4'd0);
      run(20, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'd9, 1'b0, 1'b0, 4'd0);
      run(25, 1'b1);

      // Masks: empty mask, then all channels with defaults.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 4'b0000);
      run(20, 1'b1);
      rst(1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 4'b1111);
      run(40, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic e, s, cw, cm, mw;
         logic [2:0] cc;
         logic [7:0] cd;
         logic [3:0] mi;
         e  = ($urandom_range(0, 9) != 0);
         s  = ($urandom_range(0, 39) == 0);
         cw = ($urandom_range(0, 9) == 0);
         cc = 3'($urandom_range(0, 7));
         cd = 8'($urandom_range(0, 12));
         cm = 1'($urandom_range(0, 1));
         mw = ($urandom_range(0, 24) == 0);
         mi = 4'($urandom);
         cyc(1'b1, e, s, cw, cc, cd, cm, mw, mi);
      end

      // Reset mid-period with ena high, then restart from defaults.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 4'd0);
      run(24, 1'b1);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending exp=0", q.size());
      end
      done = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
